// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a word-aligned PC, requests words from instruction
// memory and holds each returned word for the decode stage until it is accepted.
// A taken redirect aborts or drains the in-flight request. A misaligned redirect
// target is fatal: fetch parks in a halt state until reset.
//
// Ports
//   clken        clock, rising edge
//   rst          asynchronous active-low reset
//   en           fetch enable; 0 stops new requests, does not abort one in flight
//   imem_req     memory request (held from issue until ack)
//   imem_addr    word address of the request (current pc)
//   imem_ack     memory response strobe, qualifies imem_rdata
//   imem_rdata   returned instruction word
//   redirect     taken jump/branch from a later stage
//   redirect_pc  new fetch target
//   opcode       instruction word presented to decode
//   pc_out       address of the word on opcode
//   valid        opcode/pc_out hold an unconsumed instruction
//   dec_ready    decode accepts opcode this cycle
//   ill_inst     opcode is not a 32-bit encoding (low bits != 2'b11) while valid
//   fetch_err    sticky misaligned-redirect error
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clken,
    input  logic        rst,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] opcode,
    output logic [31:0] pc_out,
    output logic        valid,
    input  logic        dec_ready,
    output logic        ill_inst,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StReq, StWait, StDrain, StHalt} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] opcode_q;
    logic [31:0] pc_out_q;
    logic        valid_q;
    logic        err_q;

    logic issue;
    logic redir_ok;
    logic redir_bad;

    assign redir_ok  = redirect & (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect & (redirect_pc[1:0] != 2'b00);

    // A new request may go out only once the output slot is free or being
    // emptied this cycle; a redirect in the same cycle wins and suppresses it.
    assign issue = (state_q == StReq) & en & (~valid_q | dec_ready) & ~redirect;

    // rst gates the request so it drops the instant reset asserts, even
    // though the reset state itself would otherwise be allowed to issue.
    assign imem_req  = rst & (issue | (state_q == StWait));
    assign imem_addr = pc_q;

    assign opcode    = opcode_q;
    assign pc_out    = pc_out_q;
    assign valid     = valid_q;
    assign fetch_err = err_q;
    assign ill_inst  = valid_q & (opcode_q[1:0] != 2'b11);

    always_ff @(posedge clken or negedge rst) begin
        if (!rst) begin
            state_q  <= StReq;
            pc_q     <= RESET_PC;
            opcode_q <= 32'h0000_0000;
            pc_out_q <= 32'h0000_0000;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // Consumption by decode; a load below overrides this.
            if (valid_q && dec_ready) begin
                valid_q <= 1'b0;
            end

            unique case (state_q)
                StReq: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        if (redir_bad) begin
                            err_q   <= 1'b1;
                            state_q <= StHalt;
                        end else begin
                            pc_q <= redirect_pc;
                        end
                    end else if (issue) begin
                        state_q <= StWait;
                    end
                end

                StWait: begin
                    if (redirect) begin
                        // Any word acked in this cycle belongs to the old path.
                        valid_q <= 1'b0;
                        if (redir_bad) begin
                            err_q   <= 1'b1;
                            state_q <= imem_ack ? StHalt : StDrain;
                        end else begin
                            pc_q    <= redirect_pc;
                            state_q <= imem_ack ? StReq : StDrain;
                        end
                    end else if (imem_ack) begin
                        opcode_q <= imem_rdata;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= StReq;
                    end
                end

                StDrain: begin
                    if (redir_ok) begin
                        pc_q <= redirect_pc;
                    end
                    if (redir_bad) begin
                        err_q <= 1'b1;
                    end
                    if (imem_ack) begin
                        state_q <= (err_q || redir_bad) ? StHalt : StReq;
                    end
                end

                StHalt: begin
                    valid_q <= 1'b0;
                end

                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A memory responder acks requests after a
// programmable latency and logs every issued address; tests push the words they
// expect decode to receive, and a monitor pops and compares on each transfer.
module tb_fetch_unit;

    logic        clken = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] opcode;
    logic [31:0] pc_out;
    logic        valid;
    logic        ill_inst;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clken       (clken),
        .rst         (rst),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .valid       (valid),
        .dec_ready   (dec_ready),
        .ill_inst    (ill_inst),
        .fetch_err   (fetch_err)
    );

    always #5 clken = ~clken;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] op;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned cyc;
    } iss_t;

    exp_t        exp_q[$];
    iss_t        issued[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    int          mem_lat = 1;
    bit          mem_auto = 1'b1;
    bit          ill_mode = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] req_addr = 32'h0;

    always @(posedge clken) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ill_mode) return (a == 32'h0) ? 32'h0000_0000 : 32'h0000_0013;
        return ((a * 32'h9E37_79B9) ^ {a[15:0], 16'h5A5A}) | 32'h0000_0003;
    endfunction

    // Memory responder: acts 2ns after each rising edge, when DUT outputs are settled.
    initial forever begin
        @(posedge clken);
        #2;
        if (!rst) begin
            busy = 1'b0;
            if (mem_auto) imem_ack = 1'b0;
        end else if (mem_auto) begin
            if (imem_ack) imem_ack = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(req_addr);
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_req) begin
                req_addr = imem_addr;
                busy     = 1'b1;
                cnt      = mem_lat - 1;
                issued.push_back('{addr: imem_addr, cyc: cyc});
            end
        end
    end

    // Decode-side monitor: a transfer is valid & dec_ready at the falling edge.
    initial forever begin
        @(negedge clken);
        if (rst && valid && dec_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL transfer: got pc=%h op=%h, required no word", pc_out, opcode);
            end else begin
                mon_e = exp_q.pop_front();
                if (pc_out !== mon_e.pc || opcode !== mon_e.op) begin
                    n_err++;
                    $display("FAIL transfer: got pc=%h op=%h, required pc=%h op=%h",
                             pc_out, opcode, mon_e.pc, mon_e.op);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic en_after);
        rst      = 1'b0;
        en       = 1'b0;
        redirect = 1'b0;
        exp_q.delete();
        issued.delete();
        mem_lat  = 1;
        ill_mode = 1'b0;
        mem_auto = 1'b1;
        repeat (2) @(posedge clken);
        #1;
        rst = 1'b1;
        en  = en_after;
    endtask

    task automatic wait_issues(input int n);
        for (int i = 0; i < 60; i++) begin
            @(posedge clken);
            #1;
            if (issued.size() >= n) break;
        end
        n_cmp++;
        if (issued.size() < n) begin
            n_err++;
            $display("FAIL issue_count: got %0d requests, required %0d", issued.size(), n);
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            @(negedge clken);
            if (valid) break;
        end
        n_cmp++;
        if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL wait_valid: got valid=%b, required 1", valid);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clken);
            if (exp_q.size() == 0 && !valid) break;
        end
        n_cmp++;
        if (exp_q.size() != 0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: got %0d words pending valid=%b, required 0 and 0",
                     exp_q.size(), valid);
        end
    endtask

    task automatic check_addr(input int idx, input logic [31:0] want);
        n_cmp++;
        if (idx >= issued.size()) begin
            n_err++;
            $display("FAIL addr[%0d]: got no request, required %h", idx, want);
        end else if (issued[idx].addr !== want) begin
            n_err++;
            $display("FAIL addr[%0d]: got %h, required %h", idx, issued[idx].addr, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1;
        dec_ready = 1'b1;
        #3;
        n_cmp += 6;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, required 0", imem_req); end
        if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", valid); end
        if (opcode !== 32'h0) begin n_err++; $display("FAIL rst_opcode: got %h, required 0", opcode); end
        if (pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc_out: got %h, required 0", pc_out); end
        if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, required 0", fetch_err); end
        if (ill_inst !== 1'b0) begin n_err++; $display("FAIL rst_ill: got %b, required 0", ill_inst); end
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(4 * i), op: mem_word(32'(4 * i))});
        wait_issues(3);
        en = 1'b0;
        wait_drain();
        for (int i = 0; i < 3; i++) check_addr(i, 32'(4 * i));
        if (issued.size() >= 3) begin
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (issued[i].cyc - issued[i-1].cyc != 2) begin
                    n_err++;
                    $display("FAIL throughput[%0d]: got %0d cycles, required 2", i,
                             issued[i].cyc - issued[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_stall();
        dec_ready = 1'b0;
        do_reset(1'b1);
        exp_q.push_back('{pc: 32'h0, op: mem_word(32'h0)});
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clken);
            n_cmp++;
            if (opcode !== mem_word(32'h0) || pc_out !== 32'h0 || imem_req !== 1'b0 ||
                issued.size() != 1) begin
                n_err++;
                $display("FAIL stall[%0d]: got op=%h pc=%h req=%b reqs=%0d, required %h 0 0 1",
                         i, opcode, pc_out, imem_req, issued.size(), mem_word(32'h0));
            end
        end
        exp_q.push_back('{pc: 32'h4, op: mem_word(32'h4)});
        @(posedge clken);
        #1;
        dec_ready = 1'b1;
        wait_issues(2);
        en = 1'b0;
        wait_drain();
        check_addr(1, 32'h4);
    endtask

    task automatic test_redirect();
        dec_ready = 1'b1;
        do_reset(1'b1);
        mem_lat = 3;
        exp_q.push_back('{pc: 32'h100, op: mem_word(32'h100)});
        @(posedge clken);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clken);
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL redir_wait: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
        @(posedge clken);
        #1;
        redirect = 1'b0;
        @(negedge clken);
        n_cmp++;
        if (imem_req !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_drain: got req=%b valid=%b, required 0 0", imem_req, valid);
        end
        wait_issues(2);
        en = 1'b0;
        check_addr(1, 32'h100);
        wait_drain();
    endtask

    task automatic test_misaligned();
        dec_ready = 1'b1;
        do_reset(1'b1);
        @(posedge clken);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        @(posedge clken);
        #1;
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clken);
            n_cmp++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL halt[%0d]: got err=%b req=%b valid=%b, required 1 0 0",
                         i, fetch_err, imem_req, valid);
            end
        end
        n_cmp++;
        if (issued.size() != 1) begin
            n_err++;
            $display("FAIL halt_reqs: got %0d requests, required 1", issued.size());
        end
        do_reset(1'b0);
        n_cmp++;
        if (fetch_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear: got %b, required 0", fetch_err);
        end
    endtask

    task automatic test_wrap();
        dec_ready = 1'b1;
        do_reset(1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back('{pc: 32'hFFFF_FFFC, op: mem_word(32'hFFFF_FFFC)});
        exp_q.push_back('{pc: 32'h0, op: mem_word(32'h0)});
        @(posedge clken);
        #1;
        redirect = 1'b0;
        en       = 1'b1;
        wait_issues(2);
        en = 1'b0;
        wait_drain();
        check_addr(0, 32'hFFFF_FFFC);
        check_addr(1, 32'h0000_0000);
    endtask

    task automatic test_ill_inst();
        dec_ready = 1'b0;
        do_reset(1'b1);
        ill_mode = 1'b1;
        exp_q.push_back('{pc: 32'h0, op: 32'h0000_0000});
        exp_q.push_back('{pc: 32'h4, op: 32'h0000_0013});
        wait_valid();
        n_cmp++;
        if (ill_inst !== 1'b1 || opcode !== 32'h0) begin
            n_err++;
            $display("FAIL ill_zero: got ill=%b op=%h, required 1 0", ill_inst, opcode);
        end
        @(posedge clken);
        #1;
        dec_ready = 1'b1;
        wait_issues(2);
        en        = 1'b0;
        dec_ready = 1'b0;
        wait_valid();
        n_cmp++;
        if (ill_inst !== 1'b0 || opcode !== 32'h13) begin
            n_err++;
            $display("FAIL ill_legal: got ill=%b op=%h, required 0 13", ill_inst, opcode);
        end
        @(posedge clken);
        #1;
        dec_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_stray_ack();
        dec_ready = 1'b1;
        do_reset(1'b1);
        @(posedge clken);
        #1;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        n_cmp++;
        if (imem_req !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_midwait: got req=%b valid=%b, required 0 0", imem_req, valid);
        end
        mem_auto = 1'b0;
        repeat (2) @(posedge clken);
        #1;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEE3;
        @(posedge clken);
        #1;
        imem_ack = 1'b0;
        @(negedge clken);
        n_cmp++;
        if (valid !== 1'b0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL stray_ack: got valid=%b req=%b, required 0 0", valid, imem_req);
        end
        issued.delete();
        mem_auto = 1'b1;
        exp_q.push_back('{pc: 32'h0, op: mem_word(32'h0)});
        @(posedge clken);
        #1;
        en = 1'b1;
        wait_issues(1);
        en = 1'b0;
        wait_drain();
        check_addr(0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_ill_inst();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL have clken  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have en  input  1  fetch enable; 0 blocks new memory requests.
REQ-005 SHALL have imem_req  output  1  instruction memory request.
REQ-006 SHALL have imem_addr  output  32  word address of request.
REQ-007 SHALL have imem_ack  input  1  memory response strobe; qualifies imem_rdata in same cycle.
REQ-008 SHALL have imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have redirect  input  1  jump/branch taken, from later pipeline stage.
REQ-010 SHALL have redirect_pc  input  32  new fetch target.
REQ-011 SHALL have opcode  output  32  instruction word to decode stage.
REQ-012 SHALL have pc_out  output  32  address of the word on opcode.
REQ-013 SHALL have valid  output  1  opcode/pc_out hold an unconsumed instruction.
REQ-014 SHALL have dec_ready  input  1  decode stage accepts opcode this cycle.
REQ-015 SHALL have ill_inst  output  1  opcode[1:0] != 2'b11 while valid.
REQ-016 SHALL have fetch_err  output  1  sticky misaligned-redirect error.

Function
REQ-017 SHALL implement states REQ, WAIT, DRAIN, HALT.
REQ-018 REQ: imem_req=1 and imem_addr=pc when en=1 and (valid=0 or valid&dec_ready); next state WAIT on issue, else remain REQ with imem_req=0.
REQ-019 WAIT: imem_req held 1, imem_addr held stable until imem_ack.
REQ-020 On imem_ack in WAIT (no redirect): opcode<=imem_rdata, pc_out<=pc, valid<=1, pc<=pc+4, next state REQ.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Handshake: transfer occurs when valid&dec_ready; valid SHALL clear next cycle unless a new word is loaded in the same cycle.
REQ-023 opcode, pc_out SHALL remain stable while valid=1 and dec_ready=0.
REQ-024 Latency: request issue to valid=1 SHALL be ack cycle +1 edge; back-to-back throughput one instruction per 2 cycles with single-cycle ack.
REQ-025 redirect SHALL have priority over all other events in the same cycle.
REQ-026 redirect with redirect_pc[1:0]==0: pc<=redirect_pc, valid<=0; from WAIT without ack -> DRAIN; otherwise (including ack same cycle, data discarded) -> REQ.
REQ-027 DRAIN: imem_req=0, wait for imem_ack, discard imem_rdata, then REQ; further redirect in DRAIN updates pc only.
REQ-028 redirect with redirect_pc[1:0]!=0: fetch_err<=1, valid<=0, next state HALT (via DRAIN if request outstanding).
REQ-029 HALT: no requests, valid=0, exit only by reset.
REQ-030 en=0 SHALL not abort an outstanding request; ack still loads opcode per REQ-020.
REQ-031 ill_inst SHALL be combinational from opcode[1:0] gated by valid.

Reset
REQ-032 rst low SHALL immediately force state REQ, pc=RESET_PC, valid=0, opcode=0, pc_out=0, imem_req=0, fetch_err=0.
REQ-033 Reset mid-WAIT SHALL drop the outstanding request; a later stray imem_ack while imem_req=0 in REQ SHALL be ignored.

Verification
REQ-034 Reset release, en=1, ack 1 cycle after req, dec_ready=1 -> imem_addr 0,4,8; opcode sequence matches memory, pc_out 0,4,8.
REQ-035 dec_ready=0 for 5 cycles after first valid -> opcode/pc_out stable, no second request issued, resumes at addr 4.
REQ-036 redirect to 32'h100 while WAIT, ack 3 cycles later -> that data discarded, next imem_addr=32'h100, valid never shows stale word.
REQ-037 redirect to 32'h102 -> fetch_err=1, imem_req stays 0 until rst, valid=0.
REQ-038 pc at 32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-039 imem_rdata=32'h0000_0000 -> valid=1, ill_inst=1; rdata=32'h0000_0013 -> ill_inst=0.
